// File: rtl/cache_pkg.sv
// Shared cache definitions: controller state encoding and address-split width helpers.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    WRITE_BACK = 3'd2,
    ALLOCATE   = 3'd3,
    RESPOND    = 3'd4
  } state_t;

  function automatic int num_sets(input int cache_size, input int block_size, input int ways);
    return cache_size / (block_size * ways);
  endfunction

  function automatic int words_per_line(input int block_size, input int data_width);
    return (block_size * 8) / data_width;
  endfunction

  function automatic int byte_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_bits(input int block_size, input int data_width);
    return $clog2(words_per_line(block_size, data_width));
  endfunction

  function automatic int index_bits(input int cache_size, input int block_size, input int ways);
    return $clog2(num_sets(cache_size, block_size, ways));
  endfunction

  function automatic int tag_bits(input int addr_width, input int cache_size, input int block_size,
                                  input int ways, input int data_width);
    return addr_width - index_bits(cache_size, block_size, ways)
         - word_bits(block_size, data_width) - byte_bits(data_width);
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// Age-based LRU update: accessed way becomes youngest, younger ways age by one.
module lru_tracker #(
  parameter int NUM_WAYS = 4,
  localparam int AGE_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages,
  input  logic [AGE_W-1:0]               way,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] ages_nxt
);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign ages_nxt[w] = (AGE_W'(w) == way)     ? '0 :
                         (ages[w] < ages[way])  ? ages[w] + 1'b1 : ages[w];
  end

endmodule

// File: rtl/l1_wb_cache.sv
// Set-associative write-back, write-allocate L1 with LRU replacement and a word-serial L2 port.
module l1_wb_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 1024,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_ready,
  output logic                  cpu_hit,
  output logic [ADDR_WIDTH-1:0] l2_cache_addr,
  output logic [DATA_WIDTH-1:0] l2_cache_data_out,
  output logic                  l2_cache_read,
  output logic                  l2_cache_write,
  input  logic [DATA_WIDTH-1:0] l2_cache_data_in,
  input  logic                  l2_cache_ready
);

  localparam int SETS  = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int WORDS = words_per_line(BLOCK_SIZE, DATA_WIDTH);
  localparam int BB    = byte_bits(DATA_WIDTH);
  localparam int WB    = word_bits(BLOCK_SIZE, DATA_WIDTH);
  localparam int IB    = index_bits(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int TB    = tag_bits(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS, DATA_WIDTH);
  localparam int AGE_W = $clog2(NUM_WAYS);
  localparam int CW    = (WB > 0) ? WB : 1;
  localparam int IW    = (IB > 0) ? IB : 1;

  logic [TB-1:0]                   tag_mem   [SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]           data_mem  [SETS][NUM_WAYS][WORDS];
  logic [NUM_WAYS-1:0]             valid_mem [SETS];
  logic [NUM_WAYS-1:0]             dirty_mem [SETS];
  logic [NUM_WAYS-1:0][AGE_W-1:0]  age_mem   [SETS];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_write;
  logic [CW-1:0]         cnt;
  logic [AGE_W-1:0]      victim_q;
  logic                  hit_q;

  logic [TB-1:0]         req_tag;
  logic [IW-1:0]         req_idx;
  logic [CW-1:0]         req_word;
  logic                  hit, last;
  logic [AGE_W-1:0]      hit_way, victim, lru_way;
  logic [NUM_WAYS-1:0][AGE_W-1:0] new_ages;

  assign req_tag  = TB'(req_addr >> (BB + WB + IB));
  assign req_idx  = IW'((req_addr >> (BB + WB)) & ADDR_WIDTH'(SETS - 1));
  assign req_word = CW'((req_addr >> BB) & ADDR_WIDTH'(WORDS - 1));
  assign last     = (cnt == CW'(WORDS - 1));
  assign lru_way  = (state == COMPARE) ? hit_way : victim_q;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [TB-1:0] t,
                                                      input logic [IW-1:0] i,
                                                      input logic [CW-1:0] w);
    return (ADDR_WIDTH'(t) << (BB + WB + IB)) | (ADDR_WIDTH'(i) << (BB + WB)) | (ADDR_WIDTH'(w) << BB);
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
  end

  // Lowest invalid way wins; otherwise the oldest (ages are a permutation).
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!found && !valid_mem[req_idx][w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    if (!found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_mem[req_idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
  end

  lru_tracker #(.NUM_WAYS(NUM_WAYS)) u_lru (
    .ages     (age_mem[req_idx]),
    .way      (lru_way),
    .ages_nxt (new_ages)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cpu_read || cpu_write) state_nxt = COMPARE;
      COMPARE:    if (hit) state_nxt = RESPOND;
                  else if (valid_mem[req_idx][victim] && dirty_mem[req_idx][victim]) state_nxt = WRITE_BACK;
                  else state_nxt = ALLOCATE;
      WRITE_BACK: if (l2_cache_ready && last) state_nxt = ALLOCATE;
      ALLOCATE:   if (l2_cache_ready && last) state_nxt = RESPOND;
      RESPOND:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready         = 1'b0;
    cpu_hit           = 1'b0;
    l2_cache_read     = 1'b0;
    l2_cache_write    = 1'b0;
    l2_cache_addr     = '0;
    l2_cache_data_out = '0;
    case (state)
      WRITE_BACK: begin
        l2_cache_write    = 1'b1;
        l2_cache_addr     = word_addr(tag_mem[req_idx][victim_q], req_idx, cnt);
        l2_cache_data_out = data_mem[req_idx][victim_q][cnt];
      end
      ALLOCATE: begin
        l2_cache_read = 1'b1;
        l2_cache_addr = word_addr(req_tag, req_idx, cnt);
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        cpu_hit   = hit_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= AGE_W'(w);
      end
      req_addr     <= '0;
      req_data     <= '0;
      req_write    <= 1'b0;
      cnt          <= '0;
      victim_q     <= '0;
      hit_q        <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_read || cpu_write) begin
          req_addr  <= cpu_addr;
          req_data  <= cpu_data_in;
          req_write <= cpu_write;
        end
        COMPARE: begin
          cnt      <= '0;
          hit_q    <= hit;
          victim_q <= victim;
          if (hit) begin
            age_mem[req_idx] <= new_ages;
            if (req_write) dirty_mem[req_idx][hit_way] <= 1'b1;
            else           cpu_data_out <= data_mem[req_idx][hit_way][req_word];
          end
        end
        WRITE_BACK: if (l2_cache_ready) cnt <= last ? '0 : cnt + 1'b1;
        ALLOCATE: if (l2_cache_ready) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            valid_mem[req_idx][victim_q] <= 1'b1;
            dirty_mem[req_idx][victim_q] <= req_write;
            age_mem[req_idx]             <= new_ages;
            // The final fill word is not in the array yet when the read word is it.
            if (!req_write)
              cpu_data_out <= (req_word == cnt) ? l2_cache_data_in
                                                : data_mem[req_idx][victim_q][req_word];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == COMPARE && hit && req_write)
        data_mem[req_idx][hit_way][req_word] <= req_data;
      if (state == ALLOCATE && l2_cache_ready) begin
        data_mem[req_idx][victim_q][cnt] <= l2_cache_data_in;
        if (last) begin
          tag_mem[req_idx][victim_q] <= req_tag;
          if (req_write) data_mem[req_idx][victim_q][req_word] <= req_data;
        end
      end
    end
  end

endmodule

// File: doc/l1_wb_cache.md
L1_WB_CACHE -- requirements
Module: l1_wb_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter CACHE_SIZE, default 1024, total data capacity in bytes.
REQ-004 SHALL have parameter BLOCK_SIZE, default 16, line size in bytes (power of 2, at least DATA_WIDTH/8).
REQ-005 SHALL have parameter NUM_WAYS, default 4, associativity (power of 2, at least 2).
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: cpu_addr  in  ADDR_WIDTH  byte address; cpu_data_in  in  DATA_WIDTH  write data; cpu_read  in  1  read request; cpu_write  in  1  write request.
REQ-008 SHALL have ports: cpu_data_out  out  DATA_WIDTH  read data; cpu_ready  out  1  one-cycle completion pulse; cpu_hit  out  1  completed request hit, valid with cpu_ready.
REQ-009 SHALL have ports: l2_cache_addr  out  ADDR_WIDTH  word address; l2_cache_data_out  out  DATA_WIDTH  write-back data; l2_cache_read  out  1; l2_cache_write  out  1; l2_cache_data_in  in  DATA_WIDTH  fill data; l2_cache_ready  in  1  L2 word accepted or returned.

Function
REQ-010 Address split SHALL be tag | index (log2 of sets) | word offset (log2 of words per line) | byte offset; byte offset ignored; sets = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS).
REQ-011 Per line SHALL store tag, valid, dirty and BLOCK_SIZE*8/DATA_WIDTH data words; per set SHALL store one age value per way.
REQ-012 FSM states SHALL be IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND.
REQ-013 IDLE: on cpu_read or cpu_write, latch address, data and operation, go to COMPARE; cpu_read and cpu_write high together SHALL be treated as a write.
REQ-014 Requests arriving outside IDLE SHALL be ignored; CPU holds its request until cpu_ready.
REQ-015 COMPARE hit: a read SHALL load cpu_data_out with the addressed word; a write SHALL update the word and set dirty; either SHALL go to RESPOND with cpu_hit=1.
REQ-016 Hit latency SHALL be fixed: request sampled at edge N, cpu_ready high during cycle N+2 only.
REQ-017 COMPARE miss: the victim SHALL be the lowest-index invalid way, else the way with maximum age; a valid dirty victim SHALL go to WRITE_BACK, any other victim to ALLOCATE.
REQ-018 WRITE_BACK SHALL send each victim word in order from word 0, at address {victim tag, index, word, zero byte offset}, holding l2_cache_write, address and data stable until l2_cache_ready is sampled high; after the last word it SHALL go to ALLOCATE.
REQ-019 ALLOCATE SHALL read each line word in order from word 0, holding l2_cache_read and address until l2_cache_ready, capturing l2_cache_data_in on that edge.
REQ-020 After the last fill word it SHALL install tag, valid=1, dirty=0, then apply the pending write (setting dirty) or load read data, and go to RESPOND with cpu_hit=0.
REQ-021 l2_cache_read and l2_cache_write SHALL never both be high and SHALL be low outside WRITE_BACK/ALLOCATE.
REQ-022 RESPOND SHALL pulse cpu_ready for one cycle and return to IDLE; cpu_data_out SHALL hold its value until the next completed read.
REQ-023 LRU: on every hit or install, the accessed way's age SHALL become 0 and every way of that set with a smaller age SHALL increment; ages stay a permutation of 0..NUM_WAYS-1.

Reset
REQ-024 While rst is high at a rising edge, all valid and dirty bits SHALL clear, way w's age SHALL be w, state SHALL be IDLE, and every output SHALL be 0.
REQ-025 Reset mid-transaction SHALL abort it without completion; L2 strobes SHALL be low from the cycle after the edge; dirty data SHALL be lost.

Structure
REQ-026 State encodings and the address-split width functions SHALL live in shared package cache_pkg, for reuse by the L2 block.
REQ-027 Age update SHALL be the sub-module lru_tracker: inputs are the current set ages and the accessed way; output is the new ages.

Verification (default parameters: 16 sets, 4 words/line, index addr[7:4])
REQ-028 Cold read 0x104, L2 always ready, fill words 0xA0..0xA3 -> L2 reads at 0x100, 0x104, 0x108, 0x10C; cpu_data_out=0xA1, cpu_hit=0; repeat read -> cpu_hit=1, cpu_ready at N+2.
REQ-029 Write 0x104=0xDEADBEEF (hit); read 0x000, 0x200, 0x300; read 0x400 -> writes to 0x100..0x10C with word1=0xDEADBEEF, then reads 0x400..0x40C.
REQ-030 Miss with l2_cache_ready low 5 cycles per word -> l2_cache_read and l2_cache_addr stable across the stall; exactly 4 reads issued.
REQ-031 rst high during word 2 of a write-back -> L2 strobes 0 the next cycle, no cpu_ready; then read 0x104 -> miss, 4 fill reads.
REQ-032 cpu_read=cpu_write=1, addr 0x208, data 0x55 -> handled as write; a later read of 0x208 returns 0x55 with cpu_hit=1.
